targ_async_receiver: RTL
========================

TARG_ASYNC_RECEIVER -- requirements
Module: targ_async_receiver

Interface
REQ-001 Parameter BaudGeneratorAccWidth, default 16, width of the baud increment input; the accumulator is one bit wider.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 RxD  input  1  asynchronous serial line, idle high, LSB first.
REQ-005 parity_even  input  1  1 = frame carries an even-parity bit after bit 7.
REQ-006 two_stopbits  input  1  1 = frame carries two stop bits.
REQ-007 RxD_BaudGeneratorInc  input  BaudGeneratorAccWidth  accumulator increment for 8x oversample tick rate.
REQ-008 RxD_data  output  8  last received byte.
REQ-009 RxD_data_ready  output  1  one-clk pulse, new byte and flags valid.
REQ-010 RxD_parity_err  output  1  parity mismatch on last frame.
REQ-011 RxD_frame_err  output  1  stop bit sampled low on last frame.
REQ-012 RxD_busy  output  1  high whenever state is not IDLE.

Function
REQ-013 RxD shall pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop (rxs).
REQ-014 Accumulator shall run free every clk: acc <= acc[W-1:0] + inc; tick = acc[W]; acc resets to 0.
REQ-015 A 3-bit tick counter (cnt) shall count ticks within a bit; state changes only on tick cycles.
REQ-016 States: IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-017 IDLE: on tick with rxs==0 -> START, cnt<=0.
REQ-018 START: on tick cnt increments; at cnt==3 (4th tick, mid start bit) sample rxs: 0 -> DATA, cnt<=0, bit index<=0; 1 -> IDLE (false start, no pulse, flags unchanged).
REQ-019 DATA/PARITY/STOP states shall sample rxs on the tick where cnt==7 (8 ticks after previous sample), cnt wrapping to 0.
REQ-020 DATA: sample shifts into bit[index], LSB first; after index 7 -> PARITY if parity_even else STOP1.
REQ-021 PARITY: sampled bit compared with XOR of the 8 data bits; mismatch sets internal parity flag -> STOP1.
REQ-022 STOP1: sample 0 sets internal frame flag; -> STOP2 if two_stopbits else IDLE with completion.
REQ-023 STOP2: sample 0 sets internal frame flag; -> IDLE with completion.
REQ-024 Completion: clk after the final stop sample, RxD_data, RxD_parity_err, RxD_frame_err update together and RxD_data_ready pulses exactly 1 clk; outputs hold until next completion.
REQ-025 Return to IDLE at mid stop bit so a back-to-back start edge is accepted with no lost frame.
REQ-026 parity_even and two_stopbits shall be sampled at the IDLE->START transition and held for the frame; mid-frame changes have no effect.
REQ-027 Internal flags clear at IDLE->START; parity_err stays 0 when parity disabled.
REQ-028 inc==0: no ticks, state frozen; no spurious pulse.
REQ-029 Frame with frame error still reports RxD_data and pulses ready.

Reset
REQ-030 reset_n low on a clk edge: state IDLE, cnt 0, acc 0, sync flops 1, RxD_data 0x00, RxD_data_ready 0, RxD_parity_err 0, RxD_frame_err 0, RxD_busy 0.
REQ-031 Reset mid-frame shall abandon the frame with no ready pulse; reception resumes on the next falling edge after release.

Verification (inc=0x8000 -> tick every 2 clk, bit = 16 clk)
REQ-032 Byte 0x55, no parity, 1 stop -> one ready pulse, RxD_data=0x55, both errs 0.
REQ-033 Byte 0xA3, parity_even=1, parity bit 0 (XOR=0) -> data 0xA3, parity_err 0; same with parity bit 1 -> parity_err 1.
REQ-034 Byte 0x0F, stop bit driven low -> data 0x0F, frame_err 1, ready pulse present.
REQ-035 RxD low for 4 clk then high -> return to IDLE, no ready pulse, busy drops within 8 clk.
REQ-036 two_stopbits=1, bytes 0x12 then 0x34 back-to-back, second stop low -> two pulses, 0x12 clean, 0x34 frame_err 1.
REQ-037 reset_n low during bit 3 of 0xFF -> all outputs reset values, no pulse; next frame 0x81 received correctly.

Source files
------------

// File: rtl/targ_async_receiver.sv
// 8x-oversampled asynchronous serial receiver with an optional even-parity bit
// and one or two stop bits; the bit rate comes from a fractional accumulator.
module targ_async_receiver #(
    parameter int BaudGeneratorAccWidth = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             RxD,
    input  logic                             parity_even,
    input  logic                             two_stopbits,
    input  logic [BaudGeneratorAccWidth-1:0] RxD_BaudGeneratorInc,
    output logic [7:0]                       RxD_data,
    output logic                             RxD_data_ready,
    output logic                             RxD_parity_err,
    output logic                             RxD_frame_err,
    output logic                             RxD_busy
);

    localparam int W = BaudGeneratorAccWidth;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t     state;
    logic       rx_meta;
    logic       rxs;
    logic [W:0] acc;
    logic       tick;
    logic [2:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic       par_en;
    logic       two_stop;
    logic       par_flag;
    logic       frm_flag;

    assign tick     = acc[W];
    assign RxD_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            rx_meta        <= 1'b1;
            rxs            <= 1'b1;
            acc            <= '0;
            cnt            <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            par_en         <= 1'b0;
            two_stop       <= 1'b0;
            par_flag       <= 1'b0;
            frm_flag       <= 1'b0;
            RxD_data       <= '0;
            RxD_data_ready <= 1'b0;
            RxD_parity_err <= 1'b0;
            RxD_frame_err  <= 1'b0;
        end else begin
            rx_meta        <= RxD;
            rxs            <= rx_meta;
            acc            <= {1'b0, acc[W-1:0]} + {1'b0, RxD_BaudGeneratorInc};
            RxD_data_ready <= 1'b0;

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state    <= START;
                            cnt      <= '0;
                            par_en   <= parity_even;
                            two_stop <= two_stopbits;
                            par_flag <= 1'b0;
                            frm_flag <= 1'b0;
                        end
                    end
                    START: begin
                        if (cnt == 3'd3) begin
                            cnt <= '0;
                            if (!rxs) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            shift[bit_idx] <= rxs;
                            bit_idx        <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7)
                                state <= par_en ? PARITY : STOP1;
                        end
                    end
                    PARITY: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            par_flag <= rxs ^ (^shift);
                            state    <= STOP1;
                        end
                    end
                    STOP1: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            // Leaving at mid stop bit keeps the next start edge catchable.
                            if (two_stop) begin
                                frm_flag <= frm_flag | ~rxs;
                                state    <= STOP2;
                            end else begin
                                state          <= IDLE;
                                RxD_data       <= shift;
                                RxD_parity_err <= par_flag;
                                RxD_frame_err  <= frm_flag | ~rxs;
                                RxD_data_ready <= 1'b1;
                            end
                        end
                    end
                    STOP2: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state          <= IDLE;
                            RxD_data       <= shift;
                            RxD_parity_err <= par_flag;
                            RxD_frame_err  <= frm_flag | ~rxs;
                            RxD_data_ready <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
